multicycle_control: RTL

//  Main controller for the multi-cycle RV32I core, succeeding the single-cycle control path.

---
 rtl/multicycle_control_pkg.sv | 68 ++++++
 rtl/multicycle_control_alu_decoder.sv | 37 +++
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: state encoding,
// opcodes, ALU operation codes and datapath mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode; loads and ALU-immediates share I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_B:    imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: turns the FSM's ALUOp plus the instruction's funct
// fields into an ALUControl code, and flags funct3 values the ALU cannot do.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  // Combinational decode; op5 separates R-type (sub allowed) from addi.
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: begin
            alu_control = ALU_ADD;
            illegal     = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main controller for the multi-cycle RV32I core. One shared ALU and one
// unified memory port; each instruction takes 3-5 states plus memory waits.
//
// Memory handshake: mem_req is high in every state that owns the memory port
// (FETCH, MEMREAD, MEMWRITE). An access completes in the cycle where
// mem_req && mem_ready; mem_ready is ignored whenever mem_req is low. The FSM
// holds its state (and all request/address outputs) until completion, or
// until the wait counter hits MEM_WAIT_MAX with mem_ready still low, in which
// case it moves to the sticky FAULT state without firing any write strobe.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       fault,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  alu_op_t          alu_op;
  logic             funct_illegal;
  logic             timeout;
  logic             req_raw;
  logic             mem_write_raw;
  logic             ir_write_raw;
  logic             pc_write_raw;
  logic             reg_write_raw;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl),
    .illegal     (funct_illegal)
  );

  // Limit reached this cycle; only acted on while waiting on memory.
  assign timeout = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LIMIT);

  // Next-state and Moore output decode; the only input-dependent strobes are
  // the FETCH writes (mem_ready) and the branch PC write (zero).
  always_comb begin
    next_state    = state;
    alu_op        = ALUOP_ADD;
    req_raw       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        req_raw   = 1'b1;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          next_state   = S_DECODE;
        end else if (timeout) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_B:         next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        req_raw = 1'b1;
        if (mem_ready)    next_state = S_MEMWB;
        else if (timeout) next_state = S_FAULT;
      end
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        req_raw       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready)    next_state = S_FETCH;
        else if (timeout) next_state = S_FAULT;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        next_state = funct_illegal ? S_FAULT : S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = funct_illegal ? S_FAULT : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        case (funct3)
          3'b000: begin
            pc_write_raw = zero;
            next_state   = S_FETCH;
          end
          3'b001: begin
            pc_write_raw = !zero;
            next_state   = S_FETCH;
          end
          default: next_state = S_FAULT;
        endcase
      end
      S_JAL: begin
        // Target was computed into ALUOut during DECODE; ALU now forms PC+4 link.
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
        next_state   = S_ALUWB;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FAULT;
    endcase
  end

  // Strobes are forced low while reset is held so an aborted instruction
  // cannot write anything, even though the state already reads FETCH.
  assign mem_req  = rst & req_raw;
  assign MemWrite = rst & mem_write_raw;
  assign IRWrite  = rst & ir_write_raw;
  assign PCWrite  = rst & pc_write_raw;
  assign RegWrite = rst & reg_write_raw;
  assign ImmSrc   = imm_src_of(op);
  assign state_o  = state;

  // State register, per-access wait counter and sticky fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state <= next_state;
      fault <= (next_state == S_FAULT);
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (req_raw && !mem_ready && (wait_cnt != {CNT_W{1'b1}})) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule
